led_blink_array: RTL and testbench

//  - N_CH independent LED drivers; each runtime-configured via a valid/ready

---
 rtl/led_blink_array_if.sv | 26 ++
 rtl/led_blink_array.sv | 140 ++++++++++++++
 tb/tb_led_blink_array.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_array_if.sv
// Configuration write port for led_blink_array: valid/ready request carrying
// channel, mode, half-period and burst count, plus the write-error pulse.
interface led_blink_array_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 32,
  parameter int CNT_W = 8,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_half;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_half, cfg_count,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_half, cfg_count,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/led_blink_array.sv
// N_CH independent LED drivers (OFF / ON / BLINK / counted BURST) configured through
// a valid/ready write port. Optional macro LED_PHASE_SYNC_EN adds a sync_strobe input.
module led_blink_array #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 32,
  parameter int CNT_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
`ifdef LED_PHASE_SYNC_EN
  input  logic              sync_strobe,
`endif
  led_blink_array_if.slave  cfg,
  output logic [N_CH-1:0]   LED,
  output logic [N_CH-1:0]   done
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_ON    = 2'b01,
    ST_BLINK = 2'b10,
    ST_BURST = 2'b11
  } mode_e;

  mode_e            state_q [N_CH];
  mode_e            state_d [N_CH];
  logic [DIV_W-1:0] cnt_q   [N_CH];
  logic [DIV_W-1:0] cnt_d   [N_CH];
  logic [DIV_W-1:0] half_q  [N_CH];
  logic [DIV_W-1:0] half_d  [N_CH];
  logic [CNT_W-1:0] rem_q   [N_CH];
  logic [CNT_W-1:0] rem_d   [N_CH];
  logic [N_CH-1:0]  led_q, led_d;
  logic [N_CH-1:0]  done_q, done_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;

  logic             accept;
  logic             sync_hit;
  logic [DIV_W-1:0] half_in;

`ifdef LED_PHASE_SYNC_EN
  assign sync_hit = sync_strobe;
`else
  assign sync_hit = 1'b0;
`endif

  assign accept  = cfg.cfg_valid && ready_q;
  assign half_in = (cfg.cfg_half == '0) ? DIV_W'(1) : cfg.cfg_half;

  always_comb begin
    ready_d = 1'b1;
    err_d   = accept && (int'(cfg.cfg_ch) >= N_CH);
    led_d   = led_q;
    done_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      half_d[i]  = half_q[i];
      rem_d[i]   = rem_q[i];

      if (state_q[i] == ST_BLINK || state_q[i] == ST_BURST) begin
        if (sync_hit) begin
          cnt_d[i] = '0;
          led_d[i] = 1'b1;
        end else if (cnt_q[i] == half_q[i] - DIV_W'(1)) begin
          cnt_d[i] = '0;
          led_d[i] = ~led_q[i];
          // Bursts count falling edges; the last one parks the channel in OFF.
          if (state_q[i] == ST_BURST && led_q[i]) begin
            rem_d[i] = rem_q[i] - CNT_W'(1);
            if (rem_q[i] == CNT_W'(1)) begin
              state_d[i] = ST_OFF;
              led_d[i]   = 1'b0;
              done_d[i]  = 1'b1;
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end

      // A write to this channel overrides whatever its timer did this edge.
      if (accept && int'(cfg.cfg_ch) == i) begin
        state_d[i] = mode_e'(cfg.cfg_mode);
        cnt_d[i]   = '0;
        half_d[i]  = half_in;
        rem_d[i]   = cfg.cfg_count;
        done_d[i]  = 1'b0;
        case (mode_e'(cfg.cfg_mode))
          ST_OFF:   led_d[i] = 1'b0;
          ST_ON:    led_d[i] = 1'b1;
          ST_BLINK: led_d[i] = 1'b1;
          ST_BURST: begin
            if (cfg.cfg_count == '0) begin
              state_d[i] = ST_OFF;
              led_d[i]   = 1'b0;
              done_d[i]  = 1'b1;
            end else begin
              led_d[i]   = 1'b1;
            end
          end
          default:  led_d[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= '0;
      done_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
        half_q[i]  <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
      led_q   <= led_d;
      done_q  <= done_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        half_q[i]  <= half_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign LED           = led_q;
  assign done          = done_q;

endmodule

// File: tb/tb_led_blink_array.sv
// Directed bench for led_blink_array: per-cycle vector table plus hand-written
// sequences for reset, invalid channel, and (with LED_PHASE_SYNC_EN) phase sync.
module tb_led_blink_array;

  logic       clk;
  logic       rst_n;
  logic       sync_strobe;
  logic [3:0] led, done;
  logic [2:0] led2, done2;

  int checks   = 0;
  int failures = 0;

  led_blink_array_if #(.N_CH(4), .DIV_W(8), .CNT_W(4)) bus  ();
  led_blink_array_if #(.N_CH(3), .DIV_W(8), .CNT_W(4)) bus2 ();

  led_blink_array #(.N_CH(4), .DIV_W(8), .CNT_W(4)) dut (
    .CLK(clk),
    .RST_N(rst_n),
`ifdef LED_PHASE_SYNC_EN
    .sync_strobe(sync_strobe),
`endif
    .cfg(bus.slave),
    .LED(led),
    .done(done)
  );

  led_blink_array #(.N_CH(3), .DIV_W(8), .CNT_W(4)) dut3 (
    .CLK(clk),
    .RST_N(rst_n),
`ifdef LED_PHASE_SYNC_EN
    .sync_strobe(sync_strobe),
`endif
    .cfg(bus2.slave),
    .LED(led2),
    .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [7:0] half;
    logic [3:0] cnt;
    logic [3:0] exp_led;
    logic [3:0] exp_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vld, input logic [1:0] ch, input logic [1:0] mode,
                     input logic [7:0] half, input logic [3:0] cnt,
                     input logic [3:0] exp_led, input logic [3:0] exp_done);
    vec_t r;
    r.vld = vld; r.ch = ch; r.mode = mode; r.half = half; r.cnt = cnt;
    r.exp_led = exp_led; r.exp_done = exp_done;
    tbl.push_back(r);
  endtask

  task automatic idle(input logic [3:0] exp_led, input logic [3:0] exp_done);
    add(1'b0, 2'd0, 2'd0, 8'd7, 4'd0, exp_led, exp_done);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] half,
                    input logic [3:0] cnt);
    bus.cfg_valid = 1'b1; bus.cfg_ch = ch; bus.cfg_mode = mode;
    bus.cfg_half = half;  bus.cfg_count = cnt;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sync_strobe = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_mode = '0; bus.cfg_half = '0; bus.cfg_count = '0;
    bus2.cfg_valid = 1'b0; bus2.cfg_ch = '0; bus2.cfg_mode = '0; bus2.cfg_half = '0; bus2.cfg_count = '0;

    // BLINK ch1 H=3: 1,1,1,0,0,0,1,1,1,0
    add(1, 2'd1, 2'b10, 8'd3, 4'd0, 4'b0010, 4'b0);
    idle(4'b0010, 0); idle(4'b0010, 0); idle(4'b0000, 0); idle(4'b0000, 0);
    idle(4'b0000, 0); idle(4'b0010, 0); idle(4'b0010, 0); idle(4'b0010, 0);
    idle(4'b0000, 0);
    add(1, 2'd1, 2'b00, 8'd3, 4'd0, 4'b0000, 4'b0);
    // rewriting BLINK on the would-be toggle edge restarts the phase
    add(1, 2'd1, 2'b10, 8'd3, 4'd0, 4'b0010, 4'b0);
    idle(4'b0010, 0); idle(4'b0010, 0);
    add(1, 2'd1, 2'b10, 8'd3, 4'd0, 4'b0010, 4'b0);
    idle(4'b0010, 0); idle(4'b0010, 0); idle(4'b0000, 0);
    add(1, 2'd1, 2'b00, 8'd0, 4'd0, 4'b0000, 4'b0);
    // H=2 latched; idle rows carry cfg_half=7 which must be ignored
    add(1, 2'd1, 2'b10, 8'd2, 4'd0, 4'b0010, 4'b0);
    idle(4'b0010, 0); idle(4'b0000, 0); idle(4'b0000, 0); idle(4'b0010, 0);
    add(1, 2'd1, 2'b00, 8'd0, 4'd0, 4'b0000, 4'b0);
    // H=0 on ch3 behaves as H=1
    add(1, 2'd3, 2'b10, 8'd0, 4'd0, 4'b1000, 4'b0);
    idle(4'b0000, 0); idle(4'b1000, 0); idle(4'b0000, 0);
    add(1, 2'd3, 2'b00, 8'd0, 4'd0, 4'b0000, 4'b0);
    // ON ch0
    add(1, 2'd0, 2'b01, 8'd0, 4'd0, 4'b0001, 4'b0);
    idle(4'b0001, 0); idle(4'b0001, 0);
    add(1, 2'd0, 2'b00, 8'd0, 4'd0, 4'b0000, 4'b0);
    // BURST ch2 H=2 count=3
    add(1, 2'd2, 2'b11, 8'd2, 4'd3, 4'b0100, 4'b0);
    idle(4'b0100, 0); idle(4'b0000, 0); idle(4'b0000, 0); idle(4'b0100, 0);
    idle(4'b0100, 0); idle(4'b0000, 0); idle(4'b0000, 0); idle(4'b0100, 0);
    idle(4'b0100, 0); idle(4'b0000, 4'b0100); idle(4'b0000, 0); idle(4'b0000, 0);
    // BURST count=0 ends on the accept edge
    add(1, 2'd0, 2'b11, 8'd2, 4'd0, 4'b0000, 4'b0001);
    idle(4'b0000, 0);
    // OFF written on the final burst toggle: no done
    add(1, 2'd2, 2'b11, 8'd2, 4'd1, 4'b0100, 4'b0);
    idle(4'b0100, 0);
    add(1, 2'd2, 2'b00, 8'd2, 4'd0, 4'b0000, 4'b0);
    idle(4'b0000, 0); idle(4'b0000, 0);

    #12;
    chk("reset_led", 32'(led), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_ready", 32'(bus.cfg_ready), 0);
    chk("reset_err", 32'(bus.cfg_err), 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", 32'(bus.cfg_ready), 1);
    chk("ready2_after_release", 32'(bus2.cfg_ready), 1);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.cfg_valid = tbl[i].vld; bus.cfg_ch = tbl[i].ch; bus.cfg_mode = tbl[i].mode;
      bus.cfg_half = tbl[i].half; bus.cfg_count = tbl[i].cnt;
      step();
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].exp_led));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].exp_done));
      chk($sformatf("vec%0d_err", i), 32'(bus.cfg_err), 0);
    end
    bus.cfg_valid = 1'b0;

    // out-of-range channel on the 3-channel instance
    bus2.cfg_valid = 1'b1; bus2.cfg_ch = 2'd3; bus2.cfg_mode = 2'b01; bus2.cfg_half = 8'd1;
    step();
    bus2.cfg_valid = 1'b0;
    chk("badch_err", 32'(bus2.cfg_err), 1);
    chk("badch_led", 32'(led2), 0);
    step();
    chk("badch_err_clear", 32'(bus2.cfg_err), 0);
    chk("badch_led_hold", 32'(led2), 0);
    bus2.cfg_valid = 1'b1; bus2.cfg_ch = 2'd2; bus2.cfg_mode = 2'b01;
    step();
    bus2.cfg_valid = 1'b0;
    chk("goodch_err", 32'(bus2.cfg_err), 0);
    chk("goodch_led", 32'(led2), 32'h4);

`ifdef LED_PHASE_SYNC_EN
    wr(2'd0, 2'b10, 8'd4, 4'd0);
    step();
    wr(2'd3, 2'b10, 8'd4, 4'd0);
    step(); step();
    sync_strobe = 1'b1;
    step();
    sync_strobe = 1'b0;
    for (int n = 0; n < 12; n++) begin
      chk($sformatf("sync_led0_n%0d", n), 32'(led[0]), 32'(((n / 4) % 2) == 0));
      chk($sformatf("sync_led3_n%0d", n), 32'(led[3]), 32'(((n / 4) % 2) == 0));
      step();
    end
    wr(2'd0, 2'b00, 8'd0, 4'd0);
    wr(2'd3, 2'b00, 8'd0, 4'd0);
`endif

    // asynchronous reset mid-blink with a burst about to end
    wr(2'd2, 2'b11, 8'd2, 4'd1);
    wr(2'd1, 2'b10, 8'd3, 4'd0);
    chk("pre_reset_led", 32'(led), 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_led", 32'(led), 0);
    chk("async_reset_done", 32'(done), 0);
    chk("async_reset_ready", 32'(bus.cfg_ready), 0);
    step();
    chk("held_reset_done", 32'(done), 0);
    chk("held_reset_ready", 32'(bus.cfg_ready), 0);
    #3;
    rst_n = 1'b1;
    step();
    chk("rerelease_ready", 32'(bus.cfg_ready), 1);
    chk("rerelease_led", 32'(led), 0);
    chk("rerelease_done", 32'(done), 0);
    step();
    chk("rerelease_led_idle", 32'(led), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
